// File: rtl/rx_frame_ctrl.sv
// 16x-oversampled asynchronous serial receiver with a one-entry output holding register.
// Optional break detection is enabled by defining RX_FRAME_CTRL_BREAK_DETECT_EN.
module rx_frame_ctrl (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       DataTx,
  input  logic [1:0] BaudRate,
  input  logic [1:0] ParityType,
  input  logic       RdReady,
  output logic       RdValid,
  output logic [7:0] Data,
  output logic       ParityErr,
  output logic       FrameErr,
  output logic       Overrun,
`ifdef RX_FRAME_CTRL_BREAK_DETECT_EN
  output logic       Break,
`endif
  output logic       Busy
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        rx_prev_q, rx_prev_d;
  logic [10:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]  tick_cnt_q, tick_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [1:0]  baud_sel_q, baud_sel_d;
  logic [1:0]  par_sel_q, par_sel_d;
  logic        perr_frame_q, perr_frame_d;
  logic [7:0]  data_q, data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        perr_q, perr_d;
  logic        ferr_q, ferr_d;
  logic        overrun_q, overrun_d;
`ifdef RX_FRAME_CTRL_BREAK_DETECT_EN
  logic        brk_q, brk_d;
`endif
  logic        tick, sample, stop_evt, hs;

  function automatic logic [10:0] osr_reload(input logic [1:0] sel);
    case (sel)
      2'b00:   return 11'd1302;
      2'b01:   return 11'd651;
      2'b10:   return 11'd326;
      default: return 11'd163;
    endcase
  endfunction

  function automatic logic parity_on(input logic [1:0] sel);
    return (sel == 2'b01) || (sel == 2'b10);
  endfunction

  function automatic logic parity_err(input logic [7:0] d, input logic b, input logic [1:0] sel);
    if (!parity_on(sel)) return 1'b0;
    return (^d ^ b) ^ (sel == 2'b01);
  endfunction

  always_comb begin
    sync1_d      = DataTx;
    sync2_d      = sync1_q;
    rx_prev_d    = sync2_q;
    state_d      = state_q;
    baud_cnt_d   = baud_cnt_q;
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    baud_sel_d   = baud_sel_q;
    par_sel_d    = par_sel_q;
    perr_frame_d = perr_frame_q;
    data_d       = data_q;
    rd_valid_d   = rd_valid_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    overrun_d    = overrun_q;
`ifdef RX_FRAME_CTRL_BREAK_DETECT_EN
    brk_d        = brk_q;
`endif
    tick         = 1'b0;
    stop_evt     = 1'b0;
    hs           = rd_valid_q && RdReady;

    // Oversample divider: one tick every osr_reload() cycles while a frame is in flight
    if (state_q != S_IDLE) begin
      if (baud_cnt_q == 11'd1) begin
        tick       = 1'b1;
        baud_cnt_d = osr_reload(baud_sel_q);
        tick_cnt_d = tick_cnt_q + 4'd1;
      end else begin
        baud_cnt_d = baud_cnt_q - 11'd1;
      end
    end
    sample = tick && (tick_cnt_q == 4'd15);

    case (state_q)
      S_IDLE: begin
        if (rx_prev_q && !sync2_q) begin
          state_d      = S_START;
          baud_sel_d   = BaudRate;
          par_sel_d    = ParityType;
          baud_cnt_d   = osr_reload(BaudRate);
          tick_cnt_d   = 4'd0;
          bit_cnt_d    = 3'd0;
          perr_frame_d = 1'b0;
        end
      end
      S_START: begin
        if (tick && (tick_cnt_q == 4'd7)) begin
          tick_cnt_d = 4'd0;
          state_d    = sync2_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (sample) begin
          shift_d   = {sync2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = parity_on(par_sel_q) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (sample) begin
          perr_frame_d = parity_err(shift_q, sync2_q, par_sel_q);
          state_d      = S_STOP;
        end
      end
      S_STOP: begin
        if (sample) begin
          stop_evt = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Holding register: a completed frame replaces it only if empty or being consumed now
    if (stop_evt && (!rd_valid_q || hs)) begin
      data_d     = shift_q;
      perr_d     = perr_frame_q;
      ferr_d     = !sync2_q;
      rd_valid_d = 1'b1;
      overrun_d  = 1'b0;
`ifdef RX_FRAME_CTRL_BREAK_DETECT_EN
      brk_d      = (shift_q == 8'h00) && !sync2_q;
`endif
    end else if (stop_evt) begin
      overrun_d = 1'b1;
    end else if (hs) begin
      rd_valid_d = 1'b0;
      overrun_d  = 1'b0;
`ifdef RX_FRAME_CTRL_BREAK_DETECT_EN
      brk_d      = 1'b0;
`endif
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      baud_cnt_q   <= '0;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      baud_sel_q   <= '0;
      par_sel_q    <= '0;
      perr_frame_q <= 1'b0;
      data_q       <= '0;
      rd_valid_q   <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef RX_FRAME_CTRL_BREAK_DETECT_EN
      brk_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      rx_prev_q    <= rx_prev_d;
      baud_cnt_q   <= baud_cnt_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      baud_sel_q   <= baud_sel_d;
      par_sel_q    <= par_sel_d;
      perr_frame_q <= perr_frame_d;
      data_q       <= data_d;
      rd_valid_q   <= rd_valid_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      overrun_q    <= overrun_d;
`ifdef RX_FRAME_CTRL_BREAK_DETECT_EN
      brk_q        <= brk_d;
`endif
    end
  end

  assign RdValid   = rd_valid_q;
  assign Data      = data_q;
  assign ParityErr = perr_q;
  assign FrameErr  = ferr_q;
  assign Overrun   = overrun_q;
  assign Busy      = (state_q != S_IDLE);
`ifdef RX_FRAME_CTRL_BREAK_DETECT_EN
  assign Break     = brk_q;
`endif

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Bench for rx_frame_ctrl: serial frames are driven on DataTx, expected frames queued
// from a reference model and checked by a monitor on every consumer handshake.
module tb_rx_frame_ctrl;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       DataTx = 1'b1;
  logic [1:0] BaudRate = 2'b11;
  logic [1:0] ParityType = 2'b00;
  logic       RdReady = 1'b0;
  logic       RdValid;
  logic [7:0] Data;
  logic       ParityErr;
  logic       FrameErr;
  logic       Overrun;
  logic       Busy;
`ifdef RX_FRAME_CTRL_BREAK_DETECT_EN
  logic       Break;
`endif

  rx_frame_ctrl dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .DataTx     (DataTx),
    .BaudRate   (BaudRate),
    .ParityType (ParityType),
    .RdReady    (RdReady),
    .RdValid    (RdValid),
    .Data       (Data),
    .ParityErr  (ParityErr),
    .FrameErr   (FrameErr),
    .Overrun    (Overrun),
`ifdef RX_FRAME_CTRL_BREAK_DETECT_EN
    .Break      (Break),
`endif
    .Busy       (Busy)
  );

  always #10 Clock = ~Clock;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       ovr;
    logic       brk;
  } exp_t;

  exp_t       exp_q[$];
  int         errors = 0;
  int         checks = 0;
  bit         held = 1'b0;
  logic [7:0] rnd_d;
  logic [1:0] rnd_pt;
  logic       rnd_pb;
  logic       rnd_st;
  logic [7:0] abort_d;

  // Nominal 50 MHz clock divided by 16x the baud rate
  function automatic int osr_div(input logic [1:0] br);
    case (br)
      2'b00:   return 1302;
      2'b01:   return 651;
      2'b10:   return 326;
      default: return 163;
    endcase
  endfunction

  function automatic bit has_parity(input logic [1:0] pt);
    return (pt == 2'b01) || (pt == 2'b10);
  endfunction

  function automatic exp_t model_frame(input logic [7:0] d, input logic [1:0] pt,
                                       input logic pb, input logic stop);
    exp_t m;
    int   ones;
    ones   = $countones(d) + (pb ? 1 : 0);
    m.data = d;
    m.perr = 1'b0;
    if (pt == 2'b01) m.perr = ((ones % 2) == 0);
    if (pt == 2'b10) m.perr = ((ones % 2) == 1);
    m.ferr = !stop;
    m.ovr  = 1'b0;
    m.brk  = (d == 8'h00) && !stop;
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic send_frame(input logic [1:0] br, input logic [1:0] pt, input logic [7:0] d,
                            input logic pb, input logic stop);
    int   bp;
    exp_t e;
    bp         = 16 * osr_div(br);
    BaudRate   = br;
    ParityType = pt;
    wait_cycles(4);
    if (held && exp_q.size() > 0) begin
      e     = exp_q.pop_back();
      e.ovr = 1'b1;
      exp_q.push_back(e);
    end else begin
      exp_q.push_back(model_frame(d, pt, pb, stop));
      if (!RdReady) held = 1'b1;
    end
    DataTx = 1'b0;
    wait_cycles(bp);
    BaudRate   = 2'($urandom);
    ParityType = 2'($urandom);
    for (int i = 0; i < 8; i++) begin
      DataTx = d[i];
      wait_cycles(bp);
    end
    if (has_parity(pt)) begin
      DataTx = pb;
      wait_cycles(bp);
    end
    DataTx = stop;
    wait_cycles(bp);
    DataTx = 1'b1;
    wait_cycles(8);
  endtask

  task automatic release_consumer();
    RdReady = 1'b1;
    wait_cycles(3);
    held = 1'b0;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge Clock);
      #1;
      if (RdValid && RdReady) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got data %0h expected no frame at %0t", Data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("frame_data", 32'(Data), 32'(e.data));
          chk("frame_parity_err", 32'(ParityErr), 32'(e.perr));
          chk("frame_frame_err", 32'(FrameErr), 32'(e.ferr));
          chk("frame_overrun", 32'(Overrun), 32'(e.ovr));
`ifdef RX_FRAME_CTRL_BREAK_DETECT_EN
          chk("frame_break", 32'(Break), 32'(e.brk));
`endif
        end
      end
    end
  endtask

  initial begin
    fork
      monitor();
      begin
        repeat (1500000) @(posedge Clock);
        $display("FAIL watchdog: got no completion expected finish within cycle budget");
        $fatal(1, "bench timeout");
      end
    join_none

    // Reset state
    wait_cycles(5);
    chk("reset_rdvalid", 32'(RdValid), 32'd0);
    chk("reset_data", 32'(Data), 32'd0);
    chk("reset_parity_err", 32'(ParityErr), 32'd0);
    chk("reset_frame_err", 32'(FrameErr), 32'd0);
    chk("reset_overrun", 32'(Overrun), 32'd0);
    chk("reset_busy", 32'(Busy), 32'd0);
    Reset = 1'b0;
    wait_cycles(10);

    // 9600 baud, no parity, frame held until the consumer is ready
    send_frame(2'b10, 2'b00, 8'hA5, 1'b0, 1'b1);
    wait_cycles(200);
    chk("hold_rdvalid", 32'(RdValid), 32'd1);
    chk("hold_data", 32'(Data), 32'hA5);
    chk("hold_parity_err", 32'(ParityErr), 32'd0);
    chk("hold_frame_err", 32'(FrameErr), 32'd0);
    release_consumer();
    chk("hold_released", 32'(RdValid), 32'd0);

    // Even parity with a wrong then a correct parity bit, then a framing error
    send_frame(2'b11, 2'b10, 8'h07, 1'b0, 1'b1);
    send_frame(2'b11, 2'b10, 8'h07, 1'b1, 1'b1);
    send_frame(2'b11, 2'b00, 8'h3C, 1'b0, 1'b0);

    // False start: line low for 5 ticks only
    DataTx = 1'b0;
    wait_cycles(3 * 163);
    chk("false_start_busy", 32'(Busy), 32'd1);
    wait_cycles(2 * 163);
    DataTx = 1'b1;
    wait_cycles(16 * 163);
    chk("false_start_idle", 32'(Busy), 32'd0);
    chk("false_start_rdvalid", 32'(RdValid), 32'd0);

    // Randomized frames, parity types and stop bits
    for (int k = 0; k < 3; k++) begin
      rnd_d  = 8'($urandom);
      rnd_pt = 2'($urandom);
      rnd_pb = 1'($urandom);
      rnd_st = ($urandom_range(0, 3) != 0);
      send_frame(2'b11, rnd_pt, rnd_d, rnd_pb, rnd_st);
    end

    // Reset in the middle of data bit 4 aborts the frame
    abort_d    = 8'hC3;
    BaudRate   = 2'b11;
    ParityType = 2'b00;
    wait_cycles(4);
    DataTx = 1'b0;
    wait_cycles(16 * 163);
    for (int i = 0; i < 4; i++) begin
      DataTx = abort_d[i];
      wait_cycles(16 * 163);
    end
    DataTx = abort_d[4];
    wait_cycles(8 * 163);
    Reset  = 1'b1;
    DataTx = 1'b1;
    wait_cycles(4);
    Reset = 1'b0;
    wait_cycles(20);
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_rdvalid", 32'(RdValid), 32'd0);
    send_frame(2'b11, 2'b00, 8'h5A, 1'b0, 1'b1);

    // Break-like frame: all-zero data with a low stop bit
    send_frame(2'b11, 2'b00, 8'h00, 1'b0, 1'b0);

    // Overrun: second frame dropped while the first is unconsumed
    RdReady = 1'b0;
    wait_cycles(4);
    send_frame(2'b11, 2'b00, 8'h11, 1'b0, 1'b1);
    send_frame(2'b11, 2'b00, 8'h22, 1'b0, 1'b1);
    chk("overrun_data", 32'(Data), 32'h11);
    chk("overrun_flag", 32'(Overrun), 32'd1);
    chk("overrun_rdvalid", 32'(RdValid), 32'd1);
    release_consumer();
    chk("overrun_cleared_rdvalid", 32'(RdValid), 32'd0);
    chk("overrun_cleared_flag", 32'(Overrun), 32'd0);

    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge Clock);
    chk("drain_queue", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
